lexer_stream: RTL
=================

Name: lexer_stream

Overview:
- Byte-stream tokenizer: consumes one ASCII character per accepted cycle and emits fixed-format tokens {tag, value} into an internal output FIFO.
- Successor to the whitespace-delimited lexer, with these additions:
  - parametrised number width and FIFO depth
  - ready/valid backpressure on both sides
  - operators recognised without surrounding whitespace
  - `*`, `/`, `(`, `)` tokens, error tokens and saturation reporting
- Sits between the source byte reader and the parser stage.

Parameters:
- NUM_W, 16, bit width of numeric token value; accumulator saturates at 2^NUM_W-1
- FIFO_DEPTH, 4, output token FIFO entries; power of two, >= 2

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- I_VALID  in  1  input byte valid
- I_READY  out  1  lexer accepts byte this cycle
- I_DATA  in  8  input character
- O_VALID  out  1  token at FIFO head valid
- O_READY  in  1  consumer pops head token this cycle
- O_DATA  out  8+NUM_W  token: [NUM_W+7:NUM_W] tag, [NUM_W-1:0] value
- FOUND_EOF  out  1  sticky; EOF token has been queued
- NUM_OVF  out  1  sticky; some number saturated

Behaviour:
- Tags:
  - NUM=0x00, PLUS=0x01, MINUS=0x02, EOF=0x03, MUL=0x04, DIV=0x05, LPAR=0x06, RPAR=0x07, ERR=0xFE.
  - Value field is 0 for all tags except NUM and ERR.
- Input handshake:
  - A byte is accepted only when I_VALID && I_READY.
  - I_READY = (state != DONE) && (FIFO free entries >= 2), registered-free-count based.
  - I_READY has no combinational dependence on I_VALID.
- Byte classes:
  - digit 0x30-0x39
  - whitespace 0x09, 0x0A, 0x0D, 0x20
  - operator `+ - * / ( )` (0x2B 0x2D 0x2A 0x2F 0x28 0x29)
  - EOF 0x00 or 0xFF
  - any other byte is "other"
- FSM states:
  - IDLE (no pending number)
  - IN_NUM (accumulating)
  - DONE (EOF seen)
- IDLE transitions:
  - digit: acc<=digit; -> IN_NUM
  - whitespace: no token
  - operator: push op token
  - other: push {ERR, zero-extended byte}
  - EOF: push EOF; -> DONE
- IN_NUM transitions:
  - digit: acc <= acc*10 + digit, computed at NUM_W+4 bits. If the result is > 2^NUM_W-1, acc <= all ones and NUM_OVF <= 1; once saturated, acc stays saturated.
  - Any non-digit first pushes {NUM, acc}. In the same cycle it then pushes the byte's own token (op/ERR/EOF) if any, and goes to IDLE, or to DONE on EOF.
- Dual push:
  - Up to 2 tokens are written per cycle, NUM first.
  - This is guaranteed safe by the free>=2 rule.
- DONE:
  - I_READY=0; no further tokens are generated.
  - FIFO continues draining.
  - Exit is by RST only.
- FOUND_EOF is set in the cycle the EOF token is written. It is visible the next cycle, together with O_VALID for that token if the FIFO was empty.
- Output:
  - FIFO is show-ahead: O_VALID = !empty, O_DATA = head entry.
  - Pop on O_VALID && O_READY.
  - Push and pop in the same cycle are allowed, including at full-1.
  - O_DATA holds stable while O_VALID && !O_READY.
- Latency: token written in accept cycle N appears at O_VALID in cycle N+1 when the FIFO was empty.
- Reset:
  - Applies in any state, including mid-number and with the FIFO non-empty.
  - Clears FIFO pointers and count, acc and state (-> IDLE).
  - Outputs after reset: O_VALID=0, O_DATA=0, I_READY=1, FOUND_EOF=0, NUM_OVF=0.
- O_DATA when empty: 0.

Test Plan:
- Stream "12+3 " then 0x00, O_READY=1:
  - tokens in order {0x00,12}, {0x01,0}, {0x00,3}, {0x03,0}
  - FOUND_EOF=1 after EOF
  - I_READY=0 thereafter
- Backpressure, O_READY=0, FIFO_DEPTH=4, stream "+-*/":
  - 3 tokens accepted, I_READY low (free=1), '/' held
  - raise O_READY: head {0x01,0} pops first, then '/' is accepted
  - order preserved: PLUS, MINUS, MUL, DIV
- NUM_W=8, stream "300)":
  - tokens {0x00,255}, {0x07,0} written in the same cycle
  - NUM_OVF=1 sticky
  - with NUM_W=16 the same stream gives {0x00,300} and NUM_OVF=0
- Stream "7a" then 0x00:
  - tokens {0x00,7}, {0xFE,0x61}, {0x03,0}
- RST asserted after "45" accepted with 2 tokens queued:
  - next cycle O_VALID=0, I_READY=1
  - subsequent "9 " yields only {0x00,9}; no residue of 45
- Random I_VALID/O_READY throttling over a 200-byte expression stream:
  - token sequence matches a zero-stall golden model
  - no token lost or duplicated

Source files
------------

// File: rtl/lexer_stream.sv
// Byte-stream tokenizer: one ASCII byte per accepted cycle in, {tag,value} tokens out
// through a show-ahead FIFO. A non-digit ending a number can flush two tokens at once.
module lexer_stream #(
  parameter int NUM_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               I_VALID,
  output logic               I_READY,
  input  logic [7:0]         I_DATA,
  output logic               O_VALID,
  input  logic               O_READY,
  output logic [NUM_W+7:0]   O_DATA,
  output logic               FOUND_EOF,
  output logic               NUM_OVF
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TOK_W = NUM_W + 8;
  localparam int ACC_W = NUM_W + 4;

  localparam logic [7:0] TAG_NUM   = 8'h00;
  localparam logic [7:0] TAG_PLUS  = 8'h01;
  localparam logic [7:0] TAG_MINUS = 8'h02;
  localparam logic [7:0] TAG_EOF   = 8'h03;
  localparam logic [7:0] TAG_MUL   = 8'h04;
  localparam logic [7:0] TAG_DIV   = 8'h05;
  localparam logic [7:0] TAG_LPAR  = 8'h06;
  localparam logic [7:0] TAG_RPAR  = 8'h07;
  localparam logic [7:0] TAG_ERR   = 8'hFE;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IN_NUM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_W-1:0]   acc_q, acc_d;
  logic               found_eof_q, found_eof_d;
  logic               num_ovf_q, num_ovf_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TOK_W-1:0]   mem_q [FIFO_DEPTH];

  logic               is_digit, is_eof, has_tok;
  logic [7:0]         byte_tag;
  logic [NUM_W-1:0]   byte_val;
  logic [ACC_W-1:0]   acc_ext;
  logic               acc_sat;
  logic               accept, pop, push0, push1;
  logic [1:0]         n_push;
  logic [TOK_W-1:0]   tok0, tok1;

  // Token the current byte produces on its own, independent of any pending number.
  always_comb begin
    is_digit = (I_DATA >= 8'h30) && (I_DATA <= 8'h39);
    is_eof   = 1'b0;
    has_tok  = 1'b1;
    byte_tag = TAG_ERR;
    byte_val = NUM_W'(I_DATA);
    case (I_DATA)
      8'h2B: begin byte_tag = TAG_PLUS;  byte_val = '0; end
      8'h2D: begin byte_tag = TAG_MINUS; byte_val = '0; end
      8'h2A: begin byte_tag = TAG_MUL;   byte_val = '0; end
      8'h2F: begin byte_tag = TAG_DIV;   byte_val = '0; end
      8'h28: begin byte_tag = TAG_LPAR;  byte_val = '0; end
      8'h29: begin byte_tag = TAG_RPAR;  byte_val = '0; end
      8'h00, 8'hFF: begin byte_tag = TAG_EOF; byte_val = '0; is_eof = 1'b1; end
      8'h09, 8'h0A, 8'h0D, 8'h20: begin has_tok = 1'b0; byte_val = '0; end
      default: if (is_digit) begin has_tok = 1'b0; byte_val = '0; end
    endcase
  end

  // Four spare bits hold acc*10+9 for any acc, so the overflow compare is exact.
  assign acc_ext = ACC_W'(acc_q) * ACC_W'(10) + ACC_W'(I_DATA[3:0]);
  assign acc_sat = acc_ext > ACC_W'({NUM_W{1'b1}});

  assign I_READY = (state_q != S_DONE) && (count_q <= CNT_W'(FIFO_DEPTH - 2));
  assign accept  = I_VALID && I_READY;
  assign O_VALID = (count_q != '0);
  assign pop     = O_VALID && O_READY;
  assign O_DATA  = O_VALID ? mem_q[rd_ptr_q] : '0;
  assign FOUND_EOF = found_eof_q;
  assign NUM_OVF   = num_ovf_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    found_eof_d = found_eof_q;
    num_ovf_d   = num_ovf_q;
    push0       = 1'b0;
    push1       = 1'b0;
    tok0        = '0;
    tok1        = '0;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (is_digit) begin
            acc_d   = NUM_W'(I_DATA[3:0]);
            state_d = S_IN_NUM;
          end else if (has_tok) begin
            push0 = 1'b1;
            tok0  = {byte_tag, byte_val};
            if (is_eof) begin
              state_d     = S_DONE;
              found_eof_d = 1'b1;
            end
          end
        end
        S_IN_NUM: begin
          if (is_digit) begin
            if (acc_sat) begin
              acc_d     = '1;
              num_ovf_d = 1'b1;
            end else begin
              acc_d = acc_ext[NUM_W-1:0];
            end
          end else begin
            push0       = 1'b1;
            tok0        = {TAG_NUM, acc_q};
            push1       = has_tok;
            tok1        = {byte_tag, byte_val};
            state_d     = is_eof ? S_DONE : S_IDLE;
            found_eof_d = found_eof_q | is_eof;
          end
        end
        default: ;
      endcase
    end
  end

  assign n_push    = {1'b0, push0} + {1'b0, push1};
  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
  assign wr_ptr_d  = wr_ptr_q + PTR_W'(n_push);
  assign rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
  assign count_d   = count_q + CNT_W'(n_push) - CNT_W'(pop);

  // Entries are only written into free slots, so no write can clobber the head.
  always_ff @(posedge CLK) begin
    if (push0) mem_q[wr_ptr_q]  <= tok0;
    if (push1) mem_q[wr_ptr_p1] <= tok1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      found_eof_q <= 1'b0;
      num_ovf_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      found_eof_q <= found_eof_d;
      num_ovf_q   <= num_ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end
endmodule
